// File: rtl/alu_pkg.sv
// Shared opcode encoding and default widths for the ALU slice.
// The divider is present only when ALU_DIV_EN is defined (see alu.sv).
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int SHAMT_W    = 5;

  typedef enum logic [3:0] {
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_MUL = 4'd5,
    OP_DIV = 4'd6,
    OP_OR  = 4'd7,
    OP_AND = 4'd8,
    OP_XOR = 4'd9,
    OP_SLL = 4'd10,
    OP_SRL = 4'd11,
    OP_SLT = 4'd12
  } op_e;

endpackage

// File: rtl/alu_shifter.sv
// Logical barrel shifter for SLL/SRL; vacated bits are always zero-filled.
// Only the low SHAMT_W bits of the amount reach this block.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] amount,
  input  logic               shift_right,
  output logic [DATA_W-1:0]  shifted
);

  assign shifted = shift_right ? (data >> amount) : (data << amount);

endmodule

// File: rtl/alu.sv
// Single-cycle ALU: combinational result plus registered result/zero/div0 flags.
// Define ALU_DIV_EN to build the unsigned divider; otherwise DIV returns 0 and div0_q is tied low.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rda,
  input  logic [DATA_W-1:0] rdx,
  input  logic [3:0]        alu_decode,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] result_q,
  output logic              zero_q,
  output logic              div0_q
);

  logic [DATA_W-1:0] shift_out;

  alu_shifter #(.DATA_W(DATA_W)) u_shifter (
    .data        (rda),
    .amount      (rdx[SHAMT_W-1:0]),
    .shift_right (alu_decode == OP_SRL),
    .shifted     (shift_out)
  );

  always_comb begin
    // NOTE: default assignment first so every path drives result and no latch is inferred.
    result = '0;
    case (alu_decode)
      OP_ADD: result = rda + rdx;
      OP_SUB: result = rda - rdx;
      OP_MUL: result = rda * rdx;
`ifdef ALU_DIV_EN
      OP_DIV: result = (rdx == '0) ? '1 : (rda / rdx);
`endif
      OP_OR:  result = rda | rdx;
      OP_AND: result = rda & rdx;
      OP_XOR: result = rda ^ rdx;
      OP_SLL: result = shift_out;
      OP_SRL: result = shift_out;
      OP_SLT: result = {{(DATA_W-1){1'b0}}, (rda < rdx)};
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result;
      zero_q   <= (result == '0);
    end
  end

`ifdef ALU_DIV_EN
  always_ff @(posedge clk) begin
    if (!rst_n) div0_q <= 1'b0;
    else        div0_q <= (alu_decode == OP_DIV) && (rdx == '0);
  end
`else
  assign div0_q = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, reset behaviour and a randomized run
// against an arithmetic reference model. Expectations follow ALU_DIV_EN when defined.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] rda;
  logic [31:0] rdx;
  logic [3:0]  alu_decode;
  logic [31:0] result;
  logic [31:0] result_q;
  logic        zero_q;
  logic        div0_q;

  int vectors;
  int miscompares;

  alu #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rda        (rda),
    .rdx        (rdx),
    .alu_decode (alu_decode),
    .result     (result),
    .result_q   (result_q),
    .zero_q     (zero_q),
    .div0_q     (div0_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        exp_div0;
  } vec_t;

  // Reference model built from arithmetic definitions, not from bit operators on the datapath.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint unsigned ua, ub, sh;
    ua = 64'(a);
    ub = 64'(b);
    sh = 64'(b % 32);
    case (op)
      4'd1:  return 32'((ua + ub) % 64'h1_0000_0000);
      4'd2:  return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      4'd5:  return 32'((ua * ub) % 64'h1_0000_0000);
      4'd6:  return !DIV_EN ? 32'd0 : (ub == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      4'd7:  return a | b;
      4'd8:  return a & b;
      4'd9:  return a ^ b;
      4'd10: return 32'((ua * (64'd1 << sh)) % 64'h1_0000_0000);
      4'd11: return 32'(ua / (64'd1 << sh));
      4'd12: return (ua < ub) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    alu_decode = 4'd1; rda = 32'd5; rdx = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (result_q !== 32'd0) begin
      miscompares++; $display("FAIL reset_result_q: got %h want %h", result_q, 32'd0);
    end
    vectors++;
    if (zero_q !== 1'b1) begin
      miscompares++; $display("FAIL reset_zero_q: got %b want 1", zero_q);
    end
    vectors++;
    if (div0_q !== 1'b0) begin
      miscompares++; $display("FAIL reset_div0_q: got %b want 0", div0_q);
    end
    vectors++;
    if (result !== 32'd8) begin
      miscompares++; $display("FAIL reset_comb_result: got %h want %h", result, 32'd8);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (result_q !== 32'd8) begin
      miscompares++; $display("FAIL release_result_q: got %h want %h", result_q, 32'd8);
    end
    vectors++;
    if (zero_q !== 1'b0) begin
      miscompares++; $display("FAIL release_zero_q: got %b want 0", zero_q);
    end
  endtask

  task automatic test_directed();
    vec_t vecs[$];
    vecs.push_back('{"add_5_3",      4'd1,  32'd5,          32'd3,          32'd8,          1'b0});
    vecs.push_back('{"sub_5_3",      4'd2,  32'd5,          32'd3,          32'd2,          1'b0});
    vecs.push_back('{"sub_3_5",      4'd2,  32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0});
    vecs.push_back('{"mul_5_3",      4'd5,  32'd5,          32'd3,          32'd15,         1'b0});
    vecs.push_back('{"div_10_2",     4'd6,  32'd10,         32'd2,          DIV_EN ? 32'd5 : 32'd0, 1'b0});
    vecs.push_back('{"div_10_0",     4'd6,  32'd10,         32'd0,          DIV_EN ? 32'hFFFF_FFFF : 32'd0, DIV_EN});
    vecs.push_back('{"or_55_aa",     4'd7,  32'h55,         32'hAA,         32'hFF,         1'b0});
    vecs.push_back('{"and_55_aa",    4'd8,  32'h55,         32'hAA,         32'h0,          1'b0});
    vecs.push_back('{"xor_55_aa",    4'd9,  32'h55,         32'hAA,         32'hFF,         1'b0});
    vecs.push_back('{"sll_msb_16",   4'd10, 32'h8000_0000,  32'd16,         32'h0,          1'b0});
    vecs.push_back('{"srl_f0f0_5",   4'd11, 32'h00F0_F0F0,  32'd5,          32'h0007_8787,  1'b0});
    vecs.push_back('{"srl_1234_1",   4'd11, 32'h1234_5678,  32'd1,          32'h091A_2B3C,  1'b0});
    vecs.push_back('{"sll_1_0x21",   4'd10, 32'd1,          32'h21,         32'd2,          1'b0});
    vecs.push_back('{"slt_max_1",    4'd12, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0});
    vecs.push_back('{"slt_1_max",    4'd12, 32'd1,          32'hFFFF_FFFF,  32'd1,          1'b0});
    vecs.push_back('{"op_1111",      4'd15, 32'h1234_5678,  32'h9ABC_DEF0,  32'd0,          1'b0});
    vecs.push_back('{"op_0000",      4'd0,  32'h1234_5678,  32'h9ABC_DEF0,  32'd0,          1'b0});
    foreach (vecs[i]) begin
      alu_decode = vecs[i].op; rda = vecs[i].a; rdx = vecs[i].b;
      #1;
      vectors++;
      if (result !== vecs[i].exp) begin
        miscompares++;
        $display("FAIL %s result: got %h want %h", vecs[i].name, result, vecs[i].exp);
      end
      @(posedge clk); #1;
      vectors++;
      if (result_q !== vecs[i].exp) begin
        miscompares++;
        $display("FAIL %s result_q: got %h want %h", vecs[i].name, result_q, vecs[i].exp);
      end
      vectors++;
      if (zero_q !== (vecs[i].exp == 32'd0)) begin
        miscompares++;
        $display("FAIL %s zero_q: got %b want %b", vecs[i].name, zero_q, vecs[i].exp == 32'd0);
      end
      vectors++;
      if (div0_q !== vecs[i].exp_div0) begin
        miscompares++;
        $display("FAIL %s div0_q: got %b want %b", vecs[i].name, div0_q, vecs[i].exp_div0);
      end
    end
  endtask

  // Back-to-back random operations: every cycle a new opcode, registered outputs checked each edge.
  task automatic test_random(input int n);
    logic [31:0] exp;
    logic        exp_div0;
    for (int i = 0; i < n; i++) begin
      alu_decode = 4'($urandom_range(0, 15));
      rda = $urandom;
      case ($urandom_range(0, 3))
        0:       rdx = 32'd0;
        1:       rdx = 32'($urandom_range(0, 40));
        default: rdx = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) rda = rdx;
      exp      = ref_result(alu_decode, rda, rdx);
      exp_div0 = DIV_EN && (alu_decode == 4'd6) && (rdx == 32'd0);
      #1;
      vectors++;
      if (result !== exp) begin
        miscompares++;
        $display("FAIL rand%0d op=%h a=%h b=%h result: got %h want %h",
                 i, alu_decode, rda, rdx, result, exp);
      end
      @(posedge clk); #1;
      vectors++;
      if (result_q !== exp || zero_q !== (exp == 32'd0) || div0_q !== exp_div0) begin
        miscompares++;
        $display("FAIL rand%0d regs: got q=%h z=%b d=%b want q=%h z=%b d=%b",
                 i, result_q, zero_q, div0_q, exp, exp == 32'd0, exp_div0);
      end
    end
  endtask

  task automatic test_reset_midrun();
    alu_decode = 4'd6; rda = 32'd10; rdx = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    alu_decode = 4'd1; rda = 32'd7; rdx = 32'd9;
    @(posedge clk); #1;
    vectors++;
    if (result_q !== 32'd0 || zero_q !== 1'b1 || div0_q !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset: got q=%h z=%b d=%b want q=0 z=1 d=0", result_q, zero_q, div0_q);
    end
    vectors++;
    if (result !== 32'd16) begin
      miscompares++; $display("FAIL midrun_comb: got %h want %h", result, 32'd16);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (result_q !== 32'd16 || zero_q !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_release: got q=%h z=%b want q=10 z=0", result_q, zero_q);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_random(300);
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
